hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised stall/flush controller for the 5-stage MIPS pipeline; successor to the combinational hazard unit.
//  Adds multi-cycle load-use stalls, dcache wait freezes, taken-branch flush of configurable depth and a halt state.
//  Drives every pipeline-latch enable/flush and the PC enable; sits beside datapath, fed by latch contents.
// PARAMETERS
//  LD_STALL    1   bubbles inserted on load-use (1..7; matches dcache hit latency)
//  BR_FLUSH    2   stages squashed on taken branch/jump: 1=IF/ID, 2=IF/ID+ID/EX, 3=+EX/MEM
//  CNT_W       32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  CLK          in   1   pipeline clock
//  nRST         in   1   async active-low reset
//  ihit         in   1   icache returned instruction this cycle
//  dhit         in   1   dcache completed MEM-stage access this cycle
//  mem_dacc     in   1   MEM-stage instr reads or writes dmem
//  dec_instr    in   32  instruction in IF/ID latch
//  ex_instr     in   32  instruction in ID/EX latch
//  ex_dest      in   5   ID/EX destination reg;  ex_rfWEN in 1 its write enable
//  mem_dest     in   5   EX/MEM destination reg; mem_rfWEN in 1 its write enable
//  br_taken     in   1   branch/jump resolved taken in EX (redirect PC)
//  mem_halt     in   1   HALT opcode in EX/MEM
//  pcEN,fdEN,dxEN,xmEN,mwEN  out 1 each  latch/PC advance enables
//  fd_flush,dx_flush,xm_flush out 1 each  load bubble into latch on its next edge
//  halted       out  1   registered; pipeline stopped
// BEHAVIOUR
//  FSM (hazard_pkg::hstate_t): RUN, LDSTALL, HALTED; 3-bit stall counter scnt.
//  nRST=0: state=RUN, scnt=0, halted=0, all EN=0, all flush=0 (async). Outputs combinational from state+inputs.
//  Hazard predicates (reg $zero never hazards; rt checked only if opcode reads rt: R-type, BEQ, BNE, SW):
//   lu  = ex opcode LW & ex_rfWEN & ex_dest in {dec rs, dec rt used}
//   brh = dec opcode BEQ/BNE & ((ex_rfWEN & ex_dest match) | (mem_rfWEN & mem_dest match))
//  Priority per cycle, highest first:
//   1 HALTED: all EN=0, flushes=0; exits only by reset.
//   2 dwait = mem_dacc & !dhit: all EN=0, flushes=0, state/scnt frozen.
//   3 br_taken: pcEN=1, all other EN=1; flush first BR_FLUSH latches from IF/ID; state->RUN, scnt=0 (aborts stall).
//   4 RUN & lu: pcEN=fdEN=0, dx_flush=1, rest EN=1; if LD_STALL>1 -> LDSTALL, scnt=LD_STALL-1.
//   5 LDSTALL: same outputs as 4; scnt-- each cycle; scnt==1 -> RUN next edge.
//   6 brh: one-cycle stall as in 4, no state change (re-evaluated next cycle).
//   7 !ihit: pcEN=fdEN=0, dx_flush=1, rest EN=1.
//   8 else: all EN=1, flushes=0.
//  mem_halt & !dwait -> HALTED next edge, halted=1; EX/MEM held, mwEN=1 that edge so halt retires.
//  Flush and EN both 1 on a latch = load NOP. Enables never 1 while dwait, even with br_taken (redirect deferred).
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cycles, flush_events, dwait_cycles [CNT_W-1:0];
//   saturating, cleared by nRST, count cycles in priority 4-7 / taken flushes / priority 2; frozen when HALTED.
//  Undefined: ports absent, zero logic; stall/flush behaviour identical.
// STRUCTURE
//  hazard_pkg: hstate_t enum, LD_STALL_MAX=7, function reads_rt(opcode_t), function uses_reg(instr,reg).
//  Reuse cpu_types_pkg opcode_t/regbits_t. Sub-module hazard_perf_cnt (3 counters), instantiated under macro.
// TESTING
//  1 LD_STALL=1: LW $2 in EX, ADD $3,$2,$1 in ID -> 1 cycle pcEN=fdEN=0, dx_flush=1, then RUN.
//  2 LD_STALL=3: same -> 3 consecutive stall cycles, scnt 2,1 then RUN; dwait mid-stall extends by wait length.
//  3 LW $0 in EX, user of $0 in ID -> no stall; ADDI $2 then BEQ $2,$4 in ID -> 1-cycle brh stall.
//  4 br_taken during LDSTALL, BR_FLUSH=2 -> fd_flush=dx_flush=1, pcEN=1, state RUN next edge.
//  5 mem_dacc=1, dhit=0 for 4 cycles with br_taken=1 -> all EN=0 4 cycles; flush on 5th.
//  6 HALT in MEM -> halted=1 next edge, EN=0 forever; nRST pulse mid-LDSTALL -> RUN, scnt=0, counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction opcodes and register-index type for the
// 5-stage MIPS pipeline.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

endpackage

// File: rtl/hazard_pkg.sv
// Hazard controller types and register-use helpers.
package hazard_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        HS_RUN,
        HS_LDSTALL,
        HS_HALTED
    } hstate_t;

    localparam int unsigned LD_STALL_MAX = 7;

    // Only these formats source rt; for I-type ALU ops and LW, rt is the destination.
    function automatic logic reads_rt(opcode_t op);
        return (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
    endfunction

    // True when instr sources register r; $zero is hardwired and never a hazard.
    function automatic logic uses_reg(logic [31:0] instr, regbits_t r);
        opcode_t  op;
        regbits_t rs;
        regbits_t rt;
        logic     unused_imm;
        op         = opcode_t'(instr[31:26]);
        rs         = instr[25:21];
        rt         = instr[20:16];
        unused_imm = ^instr[15:0];
        return (r != 5'd0) && ((rs == r) || (reads_rt(op) && (rt == r)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three saturating performance counters for the hazard controller:
// stall cycles, taken-branch flush events and dcache wait cycles.
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    input  logic             dwait_inc_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] dwait_cycles_o
);

    logic [2:0]       inc;
    logic [CNT_W-1:0] cnt_q [3];

    assign inc = {dwait_inc_i, flush_inc_i, stall_inc_i};

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = cnt_q[0];
    assign flush_events_o = cnt_q[1];
    assign dwait_cycles_o = cnt_q[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline. Generates every
// pipeline-latch enable and flush plus the PC enable from latch contents.
// Define HAZARD_PERF_EN to add saturating stall/flush/dwait counters.
module hazard_ctrl
    import cpu_types_pkg::*;
    import hazard_pkg::*;
#(
    parameter int unsigned LD_STALL = 1,   // 1..LD_STALL_MAX bubbles per load-use
    parameter int unsigned BR_FLUSH = 2,   // 1=IF/ID, 2=+ID/EX, 3=+EX/MEM
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ihit_i,
    input  logic        dhit_i,
    input  logic        mem_dacc_i,
    input  logic [31:0] dec_instr_i,
    input  logic [31:0] ex_instr_i,
    input  logic [4:0]  ex_dest_i,
    input  logic        ex_rfwen_i,
    input  logic [4:0]  mem_dest_i,
    input  logic        mem_rfwen_i,
    input  logic        br_taken_i,
    input  logic        mem_halt_i,
    output logic        pc_en_o,
    output logic        fd_en_o,
    output logic        dx_en_o,
    output logic        xm_en_o,
    output logic        mw_en_o,
    output logic        fd_flush_o,
    output logic        dx_flush_o,
    output logic        xm_flush_o,
    output logic        halted_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] dwait_cycles_o
`endif
);

    localparam logic FLUSH_FD = (BR_FLUSH >= 1);
    localparam logic FLUSH_DX = (BR_FLUSH >= 2);
    localparam logic FLUSH_XM = (BR_FLUSH >= 3);

    hstate_t    state_q, state_d;
    logic [2:0] scnt_q, scnt_d;

    opcode_t ex_op, dec_op;
    logic    dwait, lu, brh;
    logic    stall_evt, flush_evt, dwait_evt;

    assign ex_op  = opcode_t'(ex_instr_i[31:26]);
    assign dec_op = opcode_t'(dec_instr_i[31:26]);
    assign dwait  = mem_dacc_i & ~dhit_i;

    assign lu  = (ex_op == LW) & ex_rfwen_i & uses_reg(dec_instr_i, ex_dest_i);
    assign brh = ((dec_op == BEQ) | (dec_op == BNE)) &
                 ((ex_rfwen_i  & uses_reg(dec_instr_i, ex_dest_i)) |
                  (mem_rfwen_i & uses_reg(dec_instr_i, mem_dest_i)));

    assign halted_o = (state_q == HS_HALTED);

    // State and stall-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HS_RUN;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next state and enables/flushes, resolved in fixed priority order.
    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        pc_en_o    = 1'b0;
        fd_en_o    = 1'b0;
        dx_en_o    = 1'b0;
        xm_en_o    = 1'b0;
        mw_en_o    = 1'b0;
        fd_flush_o = 1'b0;
        dx_flush_o = 1'b0;
        xm_flush_o = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        dwait_evt  = 1'b0;
        if (!rst_n || (state_q == HS_HALTED)) begin
            state_d = state_q;            // whole pipeline frozen
        end else if (dwait) begin
            dwait_evt = 1'b1;             // freeze; a pending redirect waits too
        end else begin
            if (br_taken_i) begin
                pc_en_o    = 1'b1;
                fd_en_o    = 1'b1;
                dx_en_o    = 1'b1;
                xm_en_o    = 1'b1;
                mw_en_o    = 1'b1;
                fd_flush_o = FLUSH_FD;
                dx_flush_o = FLUSH_DX;
                xm_flush_o = FLUSH_XM;
                state_d    = HS_RUN;      // the redirect squashes the stalled consumer
                scnt_d     = '0;
                flush_evt  = 1'b1;
            end else if ((state_q == HS_RUN && lu) || (state_q == HS_LDSTALL) ||
                         brh || !ihit_i) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                dx_en_o    = 1'b1;
                xm_en_o    = 1'b1;
                mw_en_o    = 1'b1;
                dx_flush_o = 1'b1;
                stall_evt  = 1'b1;
                if (state_q == HS_LDSTALL) begin
                    scnt_d = scnt_q - 3'd1;
                    if (scnt_q == 3'd1) state_d = HS_RUN;
                end else if (lu && (LD_STALL > 1)) begin
                    state_d = HS_LDSTALL;
                    scnt_d  = 3'(LD_STALL - 1);
                end
            end else begin
                pc_en_o = 1'b1;
                fd_en_o = 1'b1;
                dx_en_o = 1'b1;
                xm_en_o = 1'b1;
                mw_en_o = 1'b1;
            end
            // HALT keeps itself in EX/MEM but retires into MEM/WB on this edge.
            if (mem_halt_i) begin
                xm_en_o    = 1'b0;
                xm_flush_o = 1'b0;
                mw_en_o    = 1'b1;
                state_d    = HS_HALTED;
                scnt_d     = '0;
            end
        end
    end

    logic unused_bits;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_inc_i    (stall_evt),
        .flush_inc_i    (flush_evt),
        .dwait_inc_i    (dwait_evt),
        .stall_cycles_o (stall_cycles_o),
        .flush_events_o (flush_events_o),
        .dwait_cycles_o (dwait_cycles_o)
    );
    assign unused_bits = ^ex_instr_i[25:0];
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
    assign unused_bits  = ^{ex_instr_i[25:0], stall_evt, flush_evt, dwait_evt};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. dut1: LD_STALL=1, BR_FLUSH=1.
// dut3: LD_STALL=3, BR_FLUSH=2. Both share the same stimulus.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    // Output packing: {pc, fd, dx, xm, mw, fd_flush, dx_flush, xm_flush}
    localparam logic [7:0] OFF  = 8'b00000_000;
    localparam logic [7:0] RUNV = 8'b11111_000;
    localparam logic [7:0] STL  = 8'b00111_010;
    localparam logic [7:0] BR1  = 8'b11111_100;
    localparam logic [7:0] BR2  = 8'b11111_110;
    localparam logic [7:0] HLT  = 8'b11101_000;

    localparam logic [31:0] NOP      = 32'h0;
    localparam logic [31:0] LW2      = {6'h23, 5'd1, 5'd2, 16'd0};          // lw   $2,0($1)
    localparam logic [31:0] LW0      = {6'h23, 5'd1, 5'd0, 16'd0};          // lw   $0,0($1)
    localparam logic [31:0] ADD_DEP  = {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}; // add $3,$2,$1
    localparam logic [31:0] ADD_Z    = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20}; // add $3,$0,$0
    localparam logic [31:0] ADD2     = {6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20}; // add $2,$1,$1
    localparam logic [31:0] ADDI2    = {6'h08, 5'd1, 5'd2, 16'd5};          // addi $2,$1,5
    localparam logic [31:0] ADDI_RT2 = {6'h08, 5'd5, 5'd2, 16'd1};          // addi $2,$5,1
    localparam logic [31:0] BEQ24    = {6'h04, 5'd2, 5'd4, 16'd3};          // beq  $2,$4
    localparam logic [31:0] BNE52    = {6'h05, 5'd5, 5'd2, 16'd1};          // bne  $5,$2
    localparam logic [31:0] SW2      = {6'h2B, 5'd5, 5'd2, 16'd0};          // sw   $2,0($5)

    logic        clk, rst_n;
    logic        ihit, dhit, mem_dacc, ex_rfwen, mem_rfwen, br_taken, mem_halt;
    logic [31:0] dec_instr, ex_instr;
    logic [4:0]  ex_dest, mem_dest;

    logic pc1, fd1, dx1, xm1, mw1, fdf1, dxf1, xmf1, h1;
    logic pc3, fd3, dx3, xm3, mw3, fdf3, dxf3, xmf3, h3;
    logic [7:0] o1, o3;
    assign o1 = {pc1, fd1, dx1, xm1, mw1, fdf1, dxf1, xmf1};
    assign o3 = {pc3, fd3, dx3, xm3, mw3, fdf3, dxf3, xmf3};

`ifdef HAZARD_PERF_EN
    logic [31:0] sc1, fe1, dw1, sc3, fe3, dw3;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(.LD_STALL(1), .BR_FLUSH(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .ihit_i(ihit), .dhit_i(dhit), .mem_dacc_i(mem_dacc),
        .dec_instr_i(dec_instr), .ex_instr_i(ex_instr), .ex_dest_i(ex_dest),
        .ex_rfwen_i(ex_rfwen), .mem_dest_i(mem_dest), .mem_rfwen_i(mem_rfwen),
        .br_taken_i(br_taken), .mem_halt_i(mem_halt),
        .pc_en_o(pc1), .fd_en_o(fd1), .dx_en_o(dx1), .xm_en_o(xm1), .mw_en_o(mw1),
        .fd_flush_o(fdf1), .dx_flush_o(dxf1), .xm_flush_o(xmf1), .halted_o(h1)
`ifdef HAZARD_PERF_EN
        , .stall_cycles_o(sc1), .flush_events_o(fe1), .dwait_cycles_o(dw1)
`endif
    );

    hazard_ctrl #(.LD_STALL(3), .BR_FLUSH(2), .CNT_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .ihit_i(ihit), .dhit_i(dhit), .mem_dacc_i(mem_dacc),
        .dec_instr_i(dec_instr), .ex_instr_i(ex_instr), .ex_dest_i(ex_dest),
        .ex_rfwen_i(ex_rfwen), .mem_dest_i(mem_dest), .mem_rfwen_i(mem_rfwen),
        .br_taken_i(br_taken), .mem_halt_i(mem_halt),
        .pc_en_o(pc3), .fd_en_o(fd3), .dx_en_o(dx3), .xm_en_o(xm3), .mw_en_o(mw3),
        .fd_flush_o(fdf3), .dx_flush_o(dxf3), .xm_flush_o(xmf3), .halted_o(h3)
`ifdef HAZARD_PERF_EN
        , .stall_cycles_o(sc3), .flush_events_o(fe3), .dwait_cycles_o(dw3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dacc = 1'b0;
        dec_instr = NOP; ex_instr = NOP; ex_dest = 5'd0; ex_rfwen = 1'b0;
        mem_dest = 5'd0; mem_rfwen = 1'b0; br_taken = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic load_use();
        idle();
        dec_instr = ADD_DEP; ex_instr = LW2; ex_dest = 5'd2; ex_rfwen = 1'b1;
    endtask

    // The load moves on; ID/EX now holds the bubble, consumer still in IF/ID.
    task automatic bubble_in_ex();
        ex_instr = NOP; ex_dest = 5'd0; ex_rfwen = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; idle();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (o1 !== OFF) begin n_fail++; $display("FAIL rst_out dut1 got %b want %b", o1, OFF); end else $display("ok   rst_out dut1 %b", o1);
        n_cmp++; if (o3 !== OFF) begin n_fail++; $display("FAIL rst_out dut3 got %b want %b", o3, OFF); end else $display("ok   rst_out dut3 %b", o3);
        n_cmp++; if ({h1, h3} !== 2'b00) begin n_fail++; $display("FAIL rst_halted got %b want 00", {h1, h3}); end else $display("ok   rst_halted");
        n_cmp++; if (dut3.state_q !== HS_RUN || dut3.scnt_q !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d/%0d want RUN/0", dut3.state_q, dut3.scnt_q); end else $display("ok   rst_state");
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (o1 !== RUNV || o3 !== RUNV) begin n_fail++; $display("FAIL rst_run got %b/%b want %b", o1, o3, RUNV); end else $display("ok   rst_run %b", o1);
    endtask

    task automatic test_load_use();
        @(negedge clk); load_use(); #1;
        n_cmp++; if (o1 !== STL) begin n_fail++; $display("FAIL lu_c1 dut1 got %b want %b", o1, STL); end else $display("ok   lu_c1 dut1 %b", o1);
        n_cmp++; if (o3 !== STL) begin n_fail++; $display("FAIL lu_c1 dut3 got %b want %b", o3, STL); end else $display("ok   lu_c1 dut3 %b", o3);
        @(negedge clk); bubble_in_ex(); #1;
        n_cmp++; if (o1 !== RUNV) begin n_fail++; $display("FAIL lu_c2 dut1 got %b want %b", o1, RUNV); end else $display("ok   lu_c2 dut1 %b", o1);
        n_cmp++; if (o3 !== STL || dut3.scnt_q !== 3'd2) begin n_fail++; $display("FAIL lu_c2 dut3 got %b scnt %0d want %b scnt 2", o3, dut3.scnt_q, STL); end else $display("ok   lu_c2 dut3 %b", o3);
        @(negedge clk); #1;
        n_cmp++; if (o3 !== STL || dut3.scnt_q !== 3'd1) begin n_fail++; $display("FAIL lu_c3 dut3 got %b scnt %0d want %b scnt 1", o3, dut3.scnt_q, STL); end else $display("ok   lu_c3 dut3 %b", o3);
        @(negedge clk); #1;
        n_cmp++; if (o3 !== RUNV || dut3.state_q !== HS_RUN) begin n_fail++; $display("FAIL lu_c4 dut3 got %b state %0d want %b RUN", o3, dut3.state_q, RUNV); end else $display("ok   lu_c4 dut3 %b", o3);
    endtask

    task automatic test_dwait_in_stall();
        @(negedge clk); load_use(); #1;
        n_cmp++; if (o3 !== STL) begin n_fail++; $display("FAIL dws_c1 dut3 got %b want %b", o3, STL); end else $display("ok   dws_c1 dut3 %b", o3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bubble_in_ex(); mem_dacc = 1'b1; dhit = 1'b0; #1;
            n_cmp++; if (o1 !== OFF || o3 !== OFF || dut3.scnt_q !== 3'd2) begin n_fail++; $display("FAIL dws_wait%0d got %b/%b scnt %0d want %b scnt 2", i, o1, o3, dut3.scnt_q, OFF); end else $display("ok   dws_wait%0d", i);
        end
        @(negedge clk); mem_dacc = 1'b0; #1;
        n_cmp++; if (o1 !== RUNV || o3 !== STL) begin n_fail++; $display("FAIL dws_c2 got %b/%b want %b/%b", o1, o3, RUNV, STL); end else $display("ok   dws_c2");
        @(negedge clk); #1;
        n_cmp++; if (o3 !== STL) begin n_fail++; $display("FAIL dws_c3 dut3 got %b want %b", o3, STL); end else $display("ok   dws_c3 dut3 %b", o3);
        @(negedge clk); #1;
        n_cmp++; if (o3 !== RUNV) begin n_fail++; $display("FAIL dws_c4 dut3 got %b want %b", o3, RUNV); end else $display("ok   dws_c4 dut3 %b", o3);
    endtask

    typedef struct {
        logic [31:0] dec;
        logic [31:0] ex;
        logic [4:0]  exd;
        logic        exw;
        logic [4:0]  memd;
        logic        memw;
        logic        ih;
        logic [7:0]  exp;
    } vec_t;

    task automatic test_predicates();
        vec_t tbl [9];
        tbl[0] = '{ADD_Z,    LW0,   5'd0, 1'b1, 5'd0, 1'b0, 1'b1, RUNV}; // $zero never hazards
        tbl[1] = '{BEQ24,    ADDI2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, STL};  // branch vs EX producer
        tbl[2] = '{BNE52,    NOP,   5'd0, 1'b0, 5'd2, 1'b1, 1'b1, STL};  // branch rt vs MEM producer
        tbl[3] = '{ADDI_RT2, LW2,   5'd2, 1'b1, 5'd0, 1'b0, 1'b1, RUNV}; // ADDI does not read rt
        tbl[4] = '{ADD_DEP,  LW2,   5'd2, 1'b0, 5'd0, 1'b0, 1'b1, RUNV}; // load not writing
        tbl[5] = '{ADD_DEP,  ADD2,  5'd2, 1'b1, 5'd0, 1'b0, 1'b1, RUNV}; // ALU producer forwards
        tbl[6] = '{ADD_DEP,  NOP,   5'd0, 1'b0, 5'd2, 1'b1, 1'b1, RUNV}; // MEM match, non-branch
        tbl[7] = '{NOP,      NOP,   5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STL};  // icache miss
        tbl[8] = '{SW2,      LW2,   5'd2, 1'b1, 5'd0, 1'b0, 1'b1, STL};  // SW reads rt
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); idle();
            dec_instr = tbl[i].dec; ex_instr = tbl[i].ex; ex_dest = tbl[i].exd; ex_rfwen = tbl[i].exw;
            mem_dest = tbl[i].memd; mem_rfwen = tbl[i].memw; ihit = tbl[i].ih; #1;
            n_cmp++; if (o1 !== tbl[i].exp || o3 !== tbl[i].exp) begin n_fail++; $display("FAIL pred%0d got %b/%b want %b", i, o1, o3, tbl[i].exp); end else $display("ok   pred%0d %b", i, o1);
        end
        // dut3 entered the multi-cycle stall on the last vector; let it drain.
        @(negedge clk); idle(); #1;
        n_cmp++; if (o1 !== RUNV || o3 !== STL) begin n_fail++; $display("FAIL pred_drain1 got %b/%b want %b/%b", o1, o3, RUNV, STL); end else $display("ok   pred_drain1");
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++; if (o3 !== RUNV) begin n_fail++; $display("FAIL pred_drain3 dut3 got %b want %b", o3, RUNV); end else $display("ok   pred_drain3");
    endtask

    task automatic test_branch_in_stall();
        @(negedge clk); load_use(); #1;
        @(negedge clk); bubble_in_ex(); br_taken = 1'b1; #1;
        n_cmp++; if (o3 !== BR2) begin n_fail++; $display("FAIL brs dut3 got %b want %b", o3, BR2); end else $display("ok   brs dut3 %b", o3);
        n_cmp++; if (o1 !== BR1) begin n_fail++; $display("FAIL brs dut1 got %b want %b", o1, BR1); end else $display("ok   brs dut1 %b", o1);
        @(negedge clk); idle(); #1;
        n_cmp++; if (o3 !== RUNV || dut3.state_q !== HS_RUN || dut3.scnt_q !== 3'd0) begin n_fail++; $display("FAIL brs_after dut3 got %b state %0d scnt %0d want %b RUN 0", o3, dut3.state_q, dut3.scnt_q, RUNV); end else $display("ok   brs_after");
    endtask

    task automatic test_dwait_branch();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); mem_dacc = 1'b1; dhit = 1'b0; br_taken = 1'b1; #1;
            n_cmp++; if (o1 !== OFF || o3 !== OFF) begin n_fail++; $display("FAIL dwb_wait%0d got %b/%b want %b", i, o1, o3, OFF); end else $display("ok   dwb_wait%0d", i);
        end
        @(negedge clk); dhit = 1'b1; #1;
        n_cmp++; if (o1 !== BR1 || o3 !== BR2) begin n_fail++; $display("FAIL dwb_flush got %b/%b want %b/%b", o1, o3, BR1, BR2); end else $display("ok   dwb_flush");
    endtask

    task automatic test_halt();
        @(negedge clk); idle(); mem_halt = 1'b1; #1;
        n_cmp++; if (o1 !== HLT || o3 !== HLT || h1 !== 1'b0) begin n_fail++; $display("FAIL halt_retire got %b/%b h %b want %b h 0", o1, o3, h1, HLT); end else $display("ok   halt_retire");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); br_taken = (i == 0); #1;
            n_cmp++; if (o1 !== OFF || o3 !== OFF || {h1, h3} !== 2'b11) begin n_fail++; $display("FAIL halted%0d got %b/%b h %b want %b h 11", i, o1, o3, {h1, h3}, OFF); end else $display("ok   halted%0d", i);
        end
        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (o1 !== RUNV || {h1, h3} !== 2'b00) begin n_fail++; $display("FAIL halt_reset got %b h %b want %b h 00", o1, {h1, h3}, RUNV); end else $display("ok   halt_reset");
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); load_use(); #1;
        @(negedge clk); bubble_in_ex(); #1;
        n_cmp++; if (dut3.state_q !== HS_LDSTALL || dut3.scnt_q !== 3'd2) begin n_fail++; $display("FAIL rms_pre state %0d scnt %0d want LDSTALL 2", dut3.state_q, dut3.scnt_q); end else $display("ok   rms_pre");
        rst_n = 1'b0; #1;
        n_cmp++; if (o3 !== OFF || dut3.state_q !== HS_RUN || dut3.scnt_q !== 3'd0) begin n_fail++; $display("FAIL rms_rst got %b state %0d scnt %0d want %b RUN 0", o3, dut3.state_q, dut3.scnt_q, OFF); end else $display("ok   rms_rst");
`ifdef HAZARD_PERF_EN
        n_cmp++; if (sc3 !== 32'd0 || fe3 !== 32'd0 || dw3 !== 32'd0) begin n_fail++; $display("FAIL rms_cnt got %0d/%0d/%0d want 0/0/0", sc3, fe3, dw3); end else $display("ok   rms_cnt");
`endif
        @(negedge clk); idle(); rst_n = 1'b1; #1;
        n_cmp++; if (o3 !== RUNV) begin n_fail++; $display("FAIL rms_run dut3 got %b want %b", o3, RUNV); end else $display("ok   rms_run");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dwait_in_stall();
        test_predicates();
        test_branch_in_stall();
        test_dwait_branch();
        test_halt();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
